// File: rtl/conv_pkg.sv
// Geometry helpers shared between the window generator and the conv MAC array.
// The localparams describe the default 5x5 single-channel 8-bit configuration.
package conv_pkg;

  localparam int DEF_K         = 5;
  localparam int DEF_CHANNELS  = 1;
  localparam int DEF_DATA_BITS = 8;

  localparam int WIN_ELEMS = DEF_K * DEF_K;
  localparam int PIX_BITS  = DEF_CHANNELS * DEF_DATA_BITS;
  localparam int WIN_BITS  = WIN_ELEMS * PIX_BITS;

  function automatic int pix_bits(int channels, int data_bits);
    return channels * data_bits;
  endfunction

  function automatic int win_bits(int k, int channels, int data_bits);
    return k * k * channels * data_bits;
  endfunction

  // Output-grid size; trailing columns/rows not reached by the stride are dropped.
  function automatic int OUT_W(int width, int k, int stride);
    return (width - k) / stride + 1;
  endfunction

  function automatic int OUT_H(int height, int k, int stride);
    return (height - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_line_delay.sv
// One raster row of pixel delay: the output is the pixel pushed DEPTH enables ago.
// Contents are deliberately not reset; the window generator never uses stale rows.
module conv_line_delay
  import conv_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int BITS  = 8
) (
  input  logic            clk,
  input  logic            en,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] dout
);

  logic [BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator with stride, ready/valid on both sides,
// frame resync via in_sof and output-grid coordinates for each window.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BITS   = 8,
  parameter int CHANNELS    = 1,
  parameter int FILTER_SIZE = 5,
  parameter int STRIDE      = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   in_sof,
  input  logic [CHANNELS*DATA_BITS-1:0]                          data_in,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [FILTER_SIZE*FILTER_SIZE*CHANNELS*DATA_BITS-1:0]  data_out,
  output logic [$clog2(HEIGHT)-1:0]                              out_row,
  output logic [$clog2(WIDTH)-1:0]                               out_col,
  output logic                                                   frame_done
);

  localparam int K  = FILTER_SIZE;
  localparam int S  = STRIDE;
  localparam int PB = pix_bits(CHANNELS, DATA_BITS);
  localparam int WB = win_bits(K, CHANNELS, DATA_BITS);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = (S > 1) ? $clog2(S) : 1;
  localparam int OW = OUT_W(WIDTH, K, S);
  localparam int OH = OUT_H(HEIGHT, K, S);

  localparam logic [CW-1:0] COL_PRE   = CW'(K - 2);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_FINAL = CW'(K - 1 + (OW - 1) * S);
  localparam logic [RW-1:0] ROW_PRE   = RW'(K - 2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FINAL = RW'(K - 1 + (OH - 1) * S);
  localparam logic [PW-1:0] PH_LAST   = PW'(S - 1);

  logic accept, emit, last;

  logic [CW-1:0] col_q, col_e, col_n, oc_q, oc_e, oc_n;
  logic [RW-1:0] row_q, row_e, row_n, or_q, or_e, or_n;
  logic [PW-1:0] sc_q, sc_e, sc_n, sr_q, sr_e, sr_n;

  logic [PB-1:0] line_out [K-1];
  logic [PB-1:0] col_in   [K];
  logic [PB-1:0] win_q    [K][K];
  logic [PB-1:0] win_n    [K][K];
  logic [WB-1:0] win_flat;

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // Row delay chain: line 0 holds the previous row, line K-2 the oldest.
  for (genvar l = 0; l < K - 1; l++) begin : g_line
    logic [PB-1:0] line_in;
    if (l == 0) begin : g_head
      assign line_in = data_in;
    end else begin : g_tail
      assign line_in = line_out[l-1];
    end
    conv_line_delay #(.DEPTH(WIDTH), .BITS(PB)) u_line (
      .clk  (clk),
      .en   (accept),
      .din  (line_in),
      .dout (line_out[l])
    );
  end

  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_new
      assign col_in[r] = data_in;
    end else begin : g_old
      assign col_in[r] = line_out[K-2-r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_n[r][c] = win_q[r][c+1];
      win_n[r][K-1] = col_in[r];
    end
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) win_flat[(r*K+c)*PB +: PB] = win_n[r][c];
  end

  always_ff @(posedge clk) begin
    if (accept) win_q <= win_n;
  end

  // Position of the beat being offered; sof forces it to (0,0) with fresh phases.
  always_comb begin
    col_e = in_sof ? '0 : col_q;
    row_e = in_sof ? '0 : row_q;
    sc_e  = in_sof ? '0 : sc_q;
    sr_e  = in_sof ? '0 : sr_q;
    oc_e  = in_sof ? '0 : oc_q;
    or_e  = in_sof ? '0 : or_q;

    emit = (row_e >= ROW_FIRST) && (col_e >= COL_FIRST) && (sc_e == '0) && (sr_e == '0);
    last = (row_e == ROW_FINAL) && (col_e == COL_FINAL);

    col_n = col_e + 1'b1;
    row_n = row_e;
    sc_n  = sc_e;
    sr_n  = sr_e;
    oc_n  = oc_e;
    or_n  = or_e;

    if (col_e == COL_LAST) begin
      col_n = '0;
      sc_n  = '0;
      oc_n  = '0;
      if (row_e == ROW_LAST) begin
        row_n = '0;
        sr_n  = '0;
        or_n  = '0;
      end else begin
        row_n = row_e + 1'b1;
        if (row_e == ROW_PRE) begin
          sr_n = '0;
          or_n = '0;
        end else if (row_e >= ROW_FIRST) begin
          if (sr_e == PH_LAST) begin
            sr_n = '0;
            or_n = or_e + 1'b1;
          end else begin
            sr_n = sr_e + 1'b1;
          end
        end
      end
    end else if (col_e == COL_PRE) begin
      sc_n = '0;
      oc_n = '0;
    end else if (col_e >= COL_FIRST) begin
      if (sc_e == PH_LAST) begin
        sc_n = '0;
        oc_n = oc_e + 1'b1;
      end else begin
        sc_n = sc_e + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      sc_q  <= '0;
      sr_q  <= '0;
      oc_q  <= '0;
      or_q  <= '0;
    end else if (accept) begin
      col_q <= col_n;
      row_q <= row_n;
      sc_q  <= sc_n;
      sr_q  <= sr_n;
      oc_q  <= oc_n;
      or_q  <= or_n;
    end
  end

  // A new window may replace one being consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      data_out   <= '0;
    end else if (accept && emit) begin
      out_valid  <= 1'b1;
      frame_done <= last;
      out_row    <= or_e;
      out_col    <= oc_e;
      data_out   <= win_flat;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: three configurations checked against a raster-order
// window model, plus stall, sof-abort and mid-frame reset scenarios.
module tb_conv_window_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_a = 0;

  // A: 6x6 K3 S1 C1   B: 7x7 K3 S2 C1   C: 4x4 K2 S1 C3
  logic        a_iv, a_irdy, a_sof, a_ov, a_ordy, a_fd;
  logic [7:0]  a_din;
  logic [71:0] a_dout;
  logic [2:0]  a_orow, a_ocol;
  logic        b_iv, b_irdy, b_sof, b_ov, b_ordy, b_fd;
  logic [7:0]  b_din;
  logic [71:0] b_dout;
  logic [2:0]  b_orow, b_ocol;
  logic        c_iv, c_irdy, c_sof, c_ov, c_ordy, c_fd;
  logic [23:0] c_din;
  logic [95:0] c_dout;
  logic [1:0]  c_orow, c_ocol;

  conv_window_gen #(.WIDTH(6), .HEIGHT(6), .DATA_BITS(8), .CHANNELS(1), .FILTER_SIZE(3), .STRIDE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_irdy), .in_sof(a_sof), .data_in(a_din),
    .out_valid(a_ov), .out_ready(a_ordy), .data_out(a_dout), .out_row(a_orow), .out_col(a_ocol),
    .frame_done(a_fd));
  conv_window_gen #(.WIDTH(7), .HEIGHT(7), .DATA_BITS(8), .CHANNELS(1), .FILTER_SIZE(3), .STRIDE(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_irdy), .in_sof(b_sof), .data_in(b_din),
    .out_valid(b_ov), .out_ready(b_ordy), .data_out(b_dout), .out_row(b_orow), .out_col(b_ocol),
    .frame_done(b_fd));
  conv_window_gen #(.WIDTH(4), .HEIGHT(4), .DATA_BITS(8), .CHANNELS(3), .FILTER_SIZE(2), .STRIDE(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_irdy), .in_sof(c_sof), .data_in(c_din),
    .out_valid(c_ov), .out_ready(c_ordy), .data_out(c_dout), .out_row(c_orow), .out_col(c_ocol),
    .frame_done(c_fd));

  typedef struct {
    logic [127:0] data;
    int           row;
    int           col;
    logic         done;
  } win_t;

  win_t qa[$], qb[$], qc[$];
  win_t rxa[$], rxb[$], rxc[$];

  function automatic logic [23:0] pix_val(int inst, int idx);
    logic [7:0] p;
    p = 8'(idx);
    if (inst == 2) return {p + 8'd32, p + 8'd16, p};
    return {16'd0, p};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected windows of a frame of which the first n pixels are delivered.
  task automatic model_frame(input int inst, input int n);
    int w, h, k, s, pb, ow, oh;
    win_t e;
    logic [23:0] pv;
    case (inst)
      0:       begin w = 6; h = 6; k = 3; s = 1; pb = 8;  end
      1:       begin w = 7; h = 7; k = 3; s = 2; pb = 8;  end
      default: begin w = 4; h = 4; k = 2; s = 1; pb = 24; end
    endcase
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int orr = 0; orr < oh; orr++) begin
      for (int occ = 0; occ < ow; occ++) begin
        if ((orr * s + k - 1) * w + occ * s + k - 1 < n) begin
          e.data = '0;
          for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) begin
              pv = pix_val(inst, (orr * s + r) * w + occ * s + c);
              e.data = e.data | ({104'd0, pv} << ((r * k + c) * pb));
            end
          e.row  = orr;
          e.col  = occ;
          e.done = (orr == oh - 1) && (occ == ow - 1);
          case (inst)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
          endcase
        end
      end
    end
  endtask

  task automatic check_win(input int inst, input logic [127:0] d, input int r, input int c, input logic fd);
    win_t got, e;
    bit have;
    got.data = d; got.row = r; got.col = c; got.done = fd;
    have = 1'b0;
    case (inst)
      0: begin rxa.push_back(got); if (fd) done_a++; if (qa.size() > 0) begin have = 1'b1; e = qa.pop_front(); end end
      1: begin rxb.push_back(got); if (qb.size() > 0) begin have = 1'b1; e = qb.pop_front(); end end
      default: begin rxc.push_back(got); if (qc.size() > 0) begin have = 1'b1; e = qc.pop_front(); end end
    endcase
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL win%0d: unexpected window data=%0h row=%0d col=%0d", inst, d, r, c);
    end else if (e.data !== d || e.row != r || e.col != c || e.done !== fd) begin
      fails++;
      $display("FAIL win%0d: got data=%0h row=%0d col=%0d done=%0b expected data=%0h row=%0d col=%0d done=%0b",
               inst, d, r, c, fd, e.data, e.row, e.col, e.done);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_ov && a_ordy) check_win(0, 128'(a_dout), int'(a_orow), int'(a_ocol), a_fd);
      if (b_ov && b_ordy) check_win(1, 128'(b_dout), int'(b_orow), int'(b_ocol), b_fd);
      if (c_ov && c_ordy) check_win(2, 128'(c_dout), int'(c_orow), int'(c_ocol), c_fd);
    end
  end

  function automatic logic rdy(int inst);
    case (inst)
      0:       return a_irdy;
      1:       return b_irdy;
      default: return c_irdy;
    endcase
  endfunction

  function automatic logic ovf(int inst);
    case (inst)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic int qsize(int inst);
    case (inst)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  // Offer one beat; inputs change only #1 after a rising edge.
  task automatic send(input int inst, input int idx, input logic sof);
    logic [23:0] pv;
    bit ok;
    pv = pix_val(inst, idx);
    ok = 1'b0;
    case (inst)
      0:       begin a_iv = 1'b1; a_din = pv[7:0]; a_sof = sof; end
      1:       begin b_iv = 1'b1; b_din = pv[7:0]; b_sof = sof; end
      default: begin c_iv = 1'b1; c_din = pv;      c_sof = sof; end
    endcase
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rdy(inst)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: inst=%0d idx=%0d in_ready=0 expected 1", inst, idx);
    end
    @(posedge clk);
    #1;
    a_iv = 1'b0; a_sof = 1'b0;
    b_iv = 1'b0; b_sof = 1'b0;
    c_iv = 1'b0; c_sof = 1'b0;
  endtask

  task automatic send_frame(input int inst, input int n, input logic sof0);
    model_frame(inst, n);
    for (int i = 0; i < n; i++) send(inst, i, (i == 0) && sof0);
  endtask

  task automatic drain(input int inst);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (qsize(inst) == 0 && !ovf(inst)) begin ok = 1'b1; break; end
    end
    chk($sformatf("drain%0d", inst), 128'(ok), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input int inst, input int idx, input logic [127:0] d,
                     input int r, input int c, input logic dn);
    win_t w;
    int sz;
    case (inst)
      0:       begin sz = rxa.size(); if (idx < sz) w = rxa[idx]; end
      1:       begin sz = rxb.size(); if (idx < sz) w = rxb[idx]; end
      default: begin sz = rxc.size(); if (idx < sz) w = rxc[idx]; end
    endcase
    if (idx >= sz) begin
      tests++;
      fails++;
      $display("FAIL %s: window %0d missing, got only %0d", name, idx, sz);
    end else begin
      chk({name, "_data"}, w.data, d);
      chk({name, "_row"}, 128'(w.row), 128'(r));
      chk({name, "_col"}, 128'(w.col), 128'(c));
      chk({name, "_done"}, 128'(w.done), 128'(dn));
    end
  endtask

  task automatic stall_check();
    logic [71:0] hd;
    logic [2:0]  hr, hc;
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a_ov) begin seen = 1'b1; break; end
    end
    chk("stall_window_seen", 128'(seen), 128'd1);
    chk("stall_first_data", 128'(a_dout), 128'h0E0D0C080706020100);
    hd = a_dout; hr = a_orow; hc = a_ocol;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_in_ready", 128'(a_irdy), 128'd0);
      chk("stall_valid", 128'(a_ov), 128'd1);
      chk("stall_data", 128'(a_dout), 128'(hd));
      chk("stall_row", 128'(a_orow), 128'(hr));
      chk("stall_col", 128'(a_ocol), 128'(hc));
    end
    @(posedge clk);
    #1 a_ordy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_iv = 0; a_sof = 0; a_din = 0; a_ordy = 1;
    b_iv = 0; b_sof = 0; b_din = 0; b_ordy = 1;
    c_iv = 0; c_sof = 0; c_din = 0; c_ordy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", 128'(a_ov), 128'd0);
    chk("rst_a_done", 128'(a_fd), 128'd0);
    chk("rst_a_data", 128'(a_dout), 128'd0);
    chk("rst_a_rowcol", 128'({a_orow, a_ocol}), 128'd0);
    chk("rst_a_in_ready", 128'(a_irdy), 128'd1);
    chk("rst_c_valid", 128'(c_ov), 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unstalled 6x6 ramp.
    send_frame(0, 36, 1'b1);
    drain(0);
    chk("a_frame1_count", 128'(rxa.size()), 128'd16);
    pin("a_first", 0, 0, 128'h0E0D0C080706020100, 0, 0, 1'b0);
    pin("a_last", 0, 15, 128'h2322211D1C1B171615, 3, 3, 1'b1);

    // Same frame with the consumer stalled on the first window.
    a_ordy = 1'b0;
    fork
      send_frame(0, 36, 1'b1);
      stall_check();
    join
    drain(0);
    chk("a_frame2_count", 128'(rxa.size()), 128'd32);
    pin("a_stall_last", 0, 31, 128'h2322211D1C1B171615, 3, 3, 1'b1);

    // Frame aborted by sof at pixel 20, then a fresh frame.
    send_frame(0, 20, 1'b1);
    send_frame(0, 36, 1'b1);
    drain(0);
    chk("a_sof_count", 128'(rxa.size()), 128'd52);
    chk("a_sof_done_count", 128'(done_a), 128'd3);
    pin("a_sof_first_new", 0, 36, 128'h0E0D0C080706020100, 0, 0, 1'b0);

    // Reset while a window is pending mid-frame.
    send_frame(0, 18, 1'b1);
    a_ordy = 1'b0;
    @(negedge clk);
    chk("pend_valid", 128'(a_ov), 128'd1);
    chk("pend_data", 128'(a_dout), 128'h11100F0B0A09050403);
    chk("pend_col", 128'(a_ocol), 128'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 128'(a_ov), 128'd0);
    chk("mid_rst_done", 128'(a_fd), 128'd0);
    chk("mid_rst_data", 128'(a_dout), 128'd0);
    chk("mid_rst_row", 128'(a_orow), 128'd0);
    chk("mid_rst_col", 128'(a_ocol), 128'd0);
    chk("mid_rst_in_ready", 128'(a_irdy), 128'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_lost_window", 128'(qa.size()), 128'd1);
    qa.delete();
    a_ordy = 1'b1;
    send_frame(0, 36, 1'b0);
    drain(0);
    chk("a_after_rst_count", 128'(rxa.size()), 128'd71);
    chk("a_after_rst_done_count", 128'(done_a), 128'd4);
    pin("a_after_rst_first", 0, 55, 128'h0E0D0C080706020100, 0, 0, 1'b0);

    // 7x7, stride 2.
    send_frame(1, 49, 1'b1);
    drain(1);
    chk("b_count", 128'(rxb.size()), 128'd9);
    pin("b_first", 1, 0, 128'h100F0E090807020100, 0, 0, 1'b0);
    pin("b_second", 1, 1, 128'h1211100B0A09040302, 0, 1, 1'b0);
    pin("b_last", 1, 8, 128'h302F2E292827222120, 2, 2, 1'b1);

    // 3 channels, K=2.
    send_frame(2, 16, 1'b1);
    drain(2);
    chk("c_count", 128'(rxc.size()), 128'd9);
    pin("c_first", 2, 0, 128'h251505241404211101201000, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
